pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It sits beside the forwarding unit and resolves the hazards forwarding cannot cover: load-use, taken branch/jump redirect, multi-cycle mul/div occupancy of EX, and data-memory wait states. It drives the per-stage write-enables and flush strobes, keeps saturating stall and flush counters, and flags a mul/div timeout.

## Interface
- CNT_W, 32: width of the performance counters.
- MD_TIMEOUT, 64: maximum cycles in MD_BUSY before the timeout error.
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous reset, active low
- rs1_id, rs2_id  in  5 each  source registers of the instruction in ID
- rs1_use_id, rs2_use_id  in  1 each  ID instruction actually reads rs1 / rs2
- id_ex_mem_read  in  1  instruction in EX is a load
- id_ex_rd  in  5  destination register of the instruction in EX
- ex_is_muldiv  in  1  instruction in EX is a multi-cycle mul/div
- md_done  in  1  mul/div result valid this cycle
- branch_taken_ex  in  1  EX resolved a taken branch or jump
- dmem_req  in  1  MEM stage is accessing data memory
- dmem_ready  in  1  data memory completes the access this cycle
- pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write  out  1 each  stage register enables
- pc_redirect  out  1  PC takes the branch target
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  insert a bubble into that register
- md_error  out  1  sticky mul/div timeout flag
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

## Operation
- States: RUN, MD_BUSY, MEM_WAIT. Reset state is RUN.
- While rst_n=0, all enables, flushes, pc_redirect and md_error are 0, and both counters are 0.
- Defaults when out of reset: all enables are 1, and all flushes and pc_redirect are 0.
- Priority each cycle is dmem wait > mul/div > branch > load-use.
- **Mem wait** (any state, condition dmem_req && !dmem_ready): all five enables are 0 and there are no flushes.
  - From RUN or MD_BUSY, the next state is MEM_WAIT.
  - Saved return state: MD_BUSY if the machine was already in MD_BUSY, otherwise RUN.
  - MEM_WAIT exits to the saved state in the cycle dmem_ready=1, and that cycle uses the default outputs.
- **Mul/div** (RUN with ex_is_muldiv && !md_done, or MD_BUSY with !md_done):
  - pc_write, if_id_write, id_ex_write = 0; ex_mem_flush = 1; mem_wb_write = 1 (older instructions drain).
  - Next state is MD_BUSY.
  - In the cycle md_done=1 the outputs are the defaults, and MD_BUSY moves to RUN.
  - If ex_is_muldiv && md_done in RUN, there is no stall.
- **Branch** (RUN, not frozen, branch_taken_ex=1): pc_redirect=1, if_id_flush=1, id_ex_flush=1.
  - If a freeze is active, the branch is held in EX and takes effect on the release cycle.
- **Load-use** (RUN, not frozen, no branch), condition:
  - id_ex_mem_read && id_ex_rd≠0 && ((rs1_use_id && id_ex_rd==rs1_id) || (rs2_use_id && id_ex_rd==rs2_id)).
  - Response: pc_write=0, if_id_write=0, id_ex_flush=1.
  - This is a single bubble; the next cycle is covered by forwarding.
  - A taken branch suppresses load-use, because the ID instruction is flushed.
- **Timeout:** md_tmr counts cycles in MD_BUSY and clears on entry.
  - When md_tmr reaches MD_TIMEOUT-1 without md_done: md_error is set (sticky until reset), the state forces to RUN, and outputs are the defaults on the following cycle.
- **Counters:**
  - stall_cnt increments on every cycle with pc_write=0.
  - flush_cnt increments on every cycle with any flush asserted.
  - Both saturate at 2^CNT_W−1.

## Timing
- All outputs except md_error and the counters are combinational from the state and current inputs, so there is zero-cycle response.
- State, md_tmr, md_error and the counters update on the rising edge of clk and clear asynchronously on the falling edge of rst_n.
- A reset asserted mid-stall returns to RUN immediately; the return state and md_tmr are cleared.
- md_error and counter updates become visible one cycle after the causing condition.
- If dmem_ready arrives in the same cycle as md_done while in MEM_WAIT (saved state MD_BUSY): exit to MD_BUSY. md_done is ignored in MEM_WAIT, so the mul/div unit must hold md_done until the result is consumed.
- If the mem-wait condition and branch_taken_ex occur together, the freeze wins and pc_redirect=0 that cycle.

## Test plan
- Load-use: id_ex_mem_read=1, id_ex_rd=5, rs1_id=5, rs1_use_id=1 -> one cycle of pc_write=0, if_id_write=0, id_ex_flush=1; stall_cnt=1, flush_cnt=1. Same stimulus with rd=0 -> no stall.
- Branch plus load-use together -> pc_redirect=1, if_id_flush=1, id_ex_flush=1, pc_write=1.
- Mul/div: ex_is_muldiv=1, md_done at the 4th cycle -> 3 frozen cycles with ex_mem_flush=1, release in cycle 4; stall_cnt=3.
- Mem wait inside mul/div: dmem_ready low for 2 cycles while in MD_BUSY -> all enables 0 for 2 cycles, return to MD_BUSY, finish on md_done.
- Timeout with MD_TIMEOUT=8 and md_done never asserted -> md_error=1 after 8 cycles, state back to RUN, flag stays 1 until rst_n=0.
- Saturation with CNT_W=4: 20 stall cycles -> stall_cnt=15. Then rst_n pulsed low mid-stall -> counters 0, state RUN, all enables 0 during reset.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch redirect,
// multi-cycle mul/div occupancy and data-memory wait states.
module pipeline_hazard_ctrl #(
  parameter int CNT_W      = 32,
  parameter int MD_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             rs1_use_id,
  input  logic             rs2_use_id,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rd,
  input  logic             ex_is_muldiv,
  input  logic             md_done,
  input  logic             branch_taken_ex,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             pc_redirect,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             md_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic [1:0] {RUN, MD_BUSY, MEM_WAIT} state_t;
  localparam int TMR_W = $clog2(MD_TIMEOUT) + 1;

  state_t             state_q, state_d;
  logic               ret_md_q, ret_md_d;
  logic [TMR_W-1:0]   md_tmr_q, md_tmr_d;
  logic               md_error_q, md_error_d;
  logic               md_abort_q, md_abort_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  // {pc, if_id, id_ex, ex_mem, mem_wb} enables and {redirect, if_id, id_ex, ex_mem} flushes
  logic [4:0] en;
  logic [3:0] fl;
  logic       mem_wait, load_use;

  always_comb begin
    mem_wait = dmem_req && !dmem_ready;
    load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
               ((rs1_use_id && id_ex_rd == rs1_id) || (rs2_use_id && id_ex_rd == rs2_id));
  end

  always_comb begin
    en          = 5'b11111;
    fl          = 4'b0000;
    state_d     = state_q;
    ret_md_d    = ret_md_q;
    md_tmr_d    = md_tmr_q;
    md_error_d  = md_error_q;
    md_abort_d  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_wait) begin
          en       = 5'b00000;
          state_d  = MEM_WAIT;
          ret_md_d = 1'b0;
        end else if (ex_is_muldiv && !md_done && !md_abort_q) begin
          en       = 5'b00011;
          fl       = 4'b0001;
          state_d  = MD_BUSY;
          md_tmr_d = '0;
        end else if (branch_taken_ex) begin
          fl = 4'b1110;
        end else if (load_use) begin
          en = 5'b00111;
          fl = 4'b0010;
        end
      end
      MD_BUSY: begin
        if (mem_wait) begin
          en       = 5'b00000;
          state_d  = MEM_WAIT;
          ret_md_d = 1'b1;
        end else if (!md_done) begin
          en = 5'b00011;
          fl = 4'b0001;
          if (md_tmr_q == TMR_W'(MD_TIMEOUT - 1)) begin
            // abandon the op; abort suppresses an immediate re-entry next cycle
            md_error_d = 1'b1;
            md_abort_d = 1'b1;
            state_d    = RUN;
          end else begin
            md_tmr_d = md_tmr_q + 1'b1;
          end
        end else begin
          state_d = RUN;
          if (branch_taken_ex) fl = 4'b1110;
        end
      end
      MEM_WAIT: begin
        if (mem_wait) begin
          en = 5'b00000;
        end else begin
          state_d = ret_md_q ? MD_BUSY : RUN;
          if (branch_taken_ex) fl = 4'b1110;
        end
      end
      default: state_d = RUN;
    endcase

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!en[4] && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    if ((|fl[2:0]) && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      ret_md_q    <= 1'b0;
      md_tmr_q    <= '0;
      md_error_q  <= 1'b0;
      md_abort_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ret_md_q    <= ret_md_d;
      md_tmr_q    <= md_tmr_d;
      md_error_q  <= md_error_d;
      md_abort_q  <= md_abort_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Everything forced low while reset is held.
  always_comb begin
    {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = rst_n ? en : 5'b00000;
    {pc_redirect, if_id_flush, id_ex_flush, ex_mem_flush}             = rst_n ? fl : 4'b0000;
  end

  assign md_error  = md_error_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
endmodule
